// File: rtl/rate_pulse_gen.sv
// rate_pulse_gen: programmable-rate tick and square-wave generator.
// Four divide ratios can be selected. The up/dn level inputs step the
// selection. Each input is edge-detected, so a held level gives one step.
// Optional build macro RATE_PULSE_GEN_SYNC_EN puts a two-flop synchronizer
// in front of the up/dn edge detector. This adds two cycles of mode latency.
module rate_pulse_gen #(
  parameter int CNT_W = 26,
  parameter int RATE0 = 25000000,
  parameter int RATE1 = 2500000,
  parameter int RATE2 = 250000,
  parameter int RATE3 = 25000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       up,
  input  logic       dn,
  output logic       output_pulses,
  output logic       clock_out,
  output logic [1:0] mode
);

  localparam logic [CNT_W-1:0] R0 = CNT_W'(RATE0);
  localparam logic [CNT_W-1:0] R1 = CNT_W'(RATE1);
  localparam logic [CNT_W-1:0] R2 = CNT_W'(RATE2);
  localparam logic [CNT_W-1:0] R3 = CNT_W'(RATE3);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic             up_src, dn_src;
  logic             up_q, dn_q;
  logic             up_edge, dn_edge;
  logic             step_up, step_dn, mode_chg;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] rate;

`ifdef RATE_PULSE_GEN_SYNC_EN
  logic [1:0] up_sync, dn_sync;

  // Two-flop synchronizers. They reset high, so a level held across reset
  // release does not look like a rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      up_sync <= 2'b11;
      dn_sync <= 2'b11;
    end else begin
      up_sync <= {up_sync[0], up};
      dn_sync <= {dn_sync[0], dn};
    end
  end

  assign up_src = up_sync[1];
  assign dn_src = dn_sync[1];
`else
  assign up_src = up;
  assign dn_src = dn;
`endif

  // One-cycle history for rising-edge detection; resets high for the same reason.
  always_ff @(posedge clk) begin
    if (rst) begin
      up_q <= 1'b1;
      dn_q <= 1'b1;
    end else begin
      up_q <= up_src;
      dn_q <= dn_src;
    end
  end

  assign up_edge  = up_src & ~up_q;
  assign dn_edge  = dn_src & ~dn_q;
  // Coincident up and dn edges cancel out.
  assign step_up  = up_edge & ~dn_edge;
  assign step_dn  = dn_edge & ~up_edge;
  assign mode_chg = step_up | step_dn;

  // Divide ratio of the current mode
  always_comb begin
    rate = R0;
    case (mode)
      2'd0: rate = R0;
      2'd1: rate = R1;
      2'd2: rate = R2;
      2'd3: rate = R3;
      default: rate = R0;
    endcase
  end

  // Mode stepping and the divider.
  // A mode change restarts the period and takes priority over a terminal count.
  // The counter compare uses >=, so cnt cannot go past the active ratio.
  // This holds even right after a switch to a shorter ratio.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= ONE;
      mode          <= 2'd0;
      output_pulses <= 1'b0;
      clock_out     <= 1'b0;
    end else if (mode_chg) begin
      mode          <= step_up ? mode + 2'd1 : mode + 2'd3;
      cnt           <= ONE;
      output_pulses <= 1'b0;
    end else if (en) begin
      if (cnt >= rate) begin
        cnt           <= ONE;
        output_pulses <= 1'b1;
        clock_out     <= ~clock_out;
      end else begin
        cnt           <= cnt + ONE;
        output_pulses <= 1'b0;
      end
    end else begin
      output_pulses <= 1'b0;
    end
  end

endmodule
